// File: rtl/apb_slv_pkg.sv
// Shared types, widths and address-check helper for the APB completer memory.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package apb_slv_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_slv_state_e;

    // Misaligned byte addresses and addresses past the last word are errored
    function automatic logic is_err(input logic [APB_AW-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr >= APB_AW'(depth * 4));
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between requester and completer, with protocol checks.
// Latency: none (wires only).
// Backpressure: completer stretches the access phase by holding PREADY low.
interface apb_slave_mem_if (
    input logic clk,
    input logic rst
);
    import apb_slv_pkg::*;

    logic              PSEL1;
    logic              PENABLE;
    logic              PWRITE;
    logic [APB_AW-1:0] PADDR;
    logic [APB_DW-1:0] PWDATA;
    logic [APB_DW-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

    // A completed access phase must be followed by PENABLE low
    penable_drop_after_ready: assert property (
        @(posedge clk) disable iff (rst)
        (PSEL1 && PENABLE && PREADY) |=> !PENABLE
    );

    // A stretched access phase keeps PENABLE high unless the requester deselects
    penable_stable_while_waiting: assert property (
        @(posedge clk) disable iff (rst)
        (PSEL1 && PENABLE && !PREADY) |=> (PENABLE || !PSEL1)
    );

endinterface

// File: rtl/apb_slv_mem.sv
// Word-addressed flop array: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is zero-cycle.
// Backpressure: none; a write is accepted on every edge where we is high.
module apb_slv_mem
    import apb_slv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     widx,
    input  logic [APB_DW-1:0] wdat,
    input  logic [AW-1:0]     ridx,
    output logic [APB_DW-1:0] rdat
);

    logic [APB_DW-1:0] mem [DEPTH];

    // Storage: cleared on reset, single write per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdat;
        end
    end

    assign rdat = mem[ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a register memory; flags misaligned/out-of-range accesses.
// Latency: PREADY on access cycle N+1 (N=WAIT_CYCLES with APB_SLV_WAIT_EN defined, else N=0).
// Backpressure: PREADY held low for N access cycles; setup-phase stalls hold the wait count.
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             PRESET,
    apb_slave_mem_if.slave   apb
);

    localparam int AW = $clog2(DEPTH);

`ifdef APB_SLV_WAIT_EN
    localparam logic [3:0] N            = 4'(WAIT_CYCLES);
    localparam logic       RDY_AT_SETUP = (N == 4'd0);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    assign cnt_nxt = cnt + 4'd1;
`else
    // Without the wait counter every transfer completes in its first access cycle;
    // WAIT_CYCLES stays on the parameter list so both builds share one interface.
    localparam int   N            = 0 * WAIT_CYCLES;
    localparam logic RDY_AT_SETUP = (N == 0);
`endif

    apb_slv_state_e    state;
    logic [AW-1:0]     idx_q;
    logic              wr_q;
    logic [APB_DW-1:0] wdata_q;
    logic              err_q;
    logic [APB_DW-1:0] prdata_q;
    logic              pready_q;
    logic              pslverr_q;

    logic              setup_err;
    logic [AW-1:0]     rd_idx;
    logic [APB_DW-1:0] rd_dat;
    logic              mem_we;

    assign setup_err = is_err(apb.PADDR, DEPTH);
    assign rd_idx    = apb.PADDR[AW+1:2];

    // Commit only on a clean write completion; aborts and errors never touch memory
    assign mem_we = (state == ACCESS) && apb.PSEL1 && apb.PENABLE && pready_q
                    && wr_q && !err_q;

    apb_slv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (PRESET),
        .we    (mem_we),
        .widx  (idx_q),
        .wdat  (wdata_q),
        .ridx  (rd_idx),
        .rdat  (rd_dat)
    );

    // Transfer FSM: capture on setup, count wait states, then complete or abort
    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
`ifdef APB_SLV_WAIT_EN
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (apb.PSEL1 && !apb.PENABLE) begin
                        state     <= ACCESS;
                        idx_q     <= rd_idx;
                        wr_q      <= apb.PWRITE;
                        wdata_q   <= apb.PWDATA;
                        err_q     <= setup_err;
                        // Read data is sampled at setup so later address changes are ignored
                        prdata_q  <= (!apb.PWRITE && !setup_err) ? rd_dat : '0;
                        pready_q  <= RDY_AT_SETUP;
                        pslverr_q <= RDY_AT_SETUP && setup_err;
`ifdef APB_SLV_WAIT_EN
                        cnt       <= '0;
`endif
                    end
                end
                ACCESS: begin
                    if (!apb.PSEL1 || (apb.PENABLE && pready_q)) begin
                        // Completion or abort: back to idle with outputs cleared
                        state     <= IDLE;
                        prdata_q  <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else if (apb.PENABLE) begin
`ifdef APB_SLV_WAIT_EN
                        cnt       <= cnt_nxt;
                        pready_q  <= (cnt_nxt == N);
                        pslverr_q <= (cnt_nxt == N) && err_q;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = pready_q;
    assign apb.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Randomized APB bench for apb_slave_mem with a word-array reference model.
// Latency: expects PREADY on access cycle N+1.
// Backpressure: requester waits on PREADY with a bounded cycle budget.
module tb_apb_slave_mem;

    localparam int DEPTH = 16;
    localparam int WAIT  = 2;
    localparam int AW    = $clog2(DEPTH);
`ifdef APB_SLV_WAIT_EN
    localparam int N = WAIT;
`else
    localparam int N = 0;
`endif

    logic clk    = 1'b0;
    logic PRESET = 1'b1;

    always #5 clk = ~clk;

    apb_slave_mem_if bus (.clk(clk), .rst(PRESET));

    apb_slave_mem #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk    (clk),
        .PRESET (PRESET),
        .apb    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [DEPTH];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= DEPTH * 4);
    endfunction

    // One full transfer starting at the next falling edge; optional setup stall
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                        input int stall);
        int          cyc;
        logic        err;
        logic [31:0] exp_rd;
        logic [AW-1:0] idx;
        err    = addr_err(addr);
        idx    = addr[AW+1:2];
        exp_rd = (!wr && !err) ? model[idx] : 32'h0;
        @(negedge clk);
        chk_eq("idle_pready", {31'h0, bus.PREADY}, 32'h0);
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wdat;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            bus.PADDR  = $urandom;
            bus.PWDATA = $urandom;
        end
        @(negedge clk);
        bus.PENABLE = 1'b1;
        bus.PADDR   = $urandom;
        bus.PWDATA  = $urandom;
        cyc = 1;
        while (bus.PREADY !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk_eq("ready_cycle", cyc, N + 1);
        chk_eq("pslverr", {31'h0, bus.PSLVERR}, {31'h0, err});
        chk_eq("prdata", bus.PRDATA, exp_rd);
        if (wr && !err) model[idx] = wdat;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk_eq("idle_pready", {31'h0, bus.PREADY}, 32'h0);
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, 0);
        end
        idle_cycle();
    endtask

    initial begin
        logic        wr;
        logic [31:0] a;
        int          sel;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 32'h0;
        bus.PWDATA  = 32'h0;

        // Reset state
        #12;
        chk_eq("rst_pready", {31'h0, bus.PREADY}, 32'h0);
        chk_eq("rst_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
        chk_eq("rst_prdata", bus.PRDATA, 32'h0);
        @(negedge clk);
        PRESET = 1'b0;

        // Write then read back
        xfer(1'b1, 32'h4, 32'hDEADBEEF, 0);
        xfer(1'b0, 32'h4, 32'h0, 0);
        idle_cycle();
        xfer(1'b1, 32'h0, 32'h12345678, 0);
        idle_cycle();
        xfer(1'b0, 32'h0, 32'h0, 1);
        idle_cycle();

        // Error accesses leave memory untouched
        xfer(1'b1, 32'h40, 32'hCAFEF00D, 0);
        xfer(1'b0, 32'h2, 32'h0, 0);
        xfer(1'b1, 32'h6, 32'hBAD0BAD0, 0);
        idle_cycle();
        sweep();

        // Abort of a write to 0xC
        @(negedge clk);
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'hC;
        bus.PWDATA  = 32'hA5A5A5A5;
        if (N >= 2) begin
            @(negedge clk);
            bus.PENABLE = 1'b1;
            chk_eq("abort_wait1", {31'h0, bus.PREADY}, 32'h0);
            @(negedge clk);
            chk_eq("abort_wait2", {31'h0, bus.PREADY}, 32'h0);
        end else begin
            @(negedge clk);
        end
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
        @(negedge clk);
        chk_eq("abort_pready", {31'h0, bus.PREADY}, 32'h0);
        chk_eq("abort_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
        chk_eq("abort_prdata", bus.PRDATA, 32'h0);
        xfer(1'b0, 32'hC, 32'h0, 0);
        idle_cycle();

        // Back-to-back writes then reads
        xfer(1'b1, 32'h0, 32'h1, 0);
        xfer(1'b1, 32'h4, 32'h2, 0);
        xfer(1'b1, 32'h8, 32'h3, 0);
        xfer(1'b0, 32'h0, 32'h0, 0);
        xfer(1'b0, 32'h4, 32'h0, 0);
        xfer(1'b0, 32'h8, 32'h0, 0);
        idle_cycle();

        // Randomized mix of good, misaligned and out-of-range accesses
        for (int t = 0; t < 60; t++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else if (sel == 1) a = 32'(DEPTH * 4 + $urandom_range(0, 255));
            else               a = 32'($urandom_range(0, DEPTH - 1) * 4);
            xfer(wr, a, $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        sweep();

        // Reset in the middle of a write to 0x8
        xfer(1'b1, 32'h8, 32'h55AA55AA, 0);
        @(negedge clk);
        bus.PSEL1   = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = 32'h8;
        bus.PWDATA  = 32'h11111111;
        @(negedge clk);
        bus.PENABLE = 1'b1;
        #2;
        PRESET = 1'b1;
        #1;
        chk_eq("midrst_pready", {31'h0, bus.PREADY}, 32'h0);
        chk_eq("midrst_pslverr", {31'h0, bus.PSLVERR}, 32'h0);
        chk_eq("midrst_prdata", bus.PRDATA, 32'h0);
        @(negedge clk);
        bus.PSEL1   = 1'b0;
        bus.PENABLE = 1'b0;
        PRESET      = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        xfer(1'b0, 32'h8, 32'h0, 0);
        idle_cycle();
        sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
